// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and opcode encodings.
package alu_pkg;

  // Default operand width; the result is always twice this wide.
  localparam int ALU_WIDTH_DEFAULT = 4;

  // Operation select. All eight codes are assigned so no opcode is undefined.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NOT  = 3'b101,
    OP_XOR  = 3'b110,
    OP_XNOR = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational datapath: maps (a, b, opcode) to a 2*WIDTH-bit result.
// Arithmetic works on zero-extended operands, so ADD and MUL cannot overflow
// and SUB wraps modulo 2^(2*WIDTH). Logic ops fill only the low WIDTH bits.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [WIDTH-1:0]   zero_hi;

  assign a_ext   = {{WIDTH{1'b0}}, a};
  assign b_ext   = {{WIDTH{1'b0}}, b};
  assign zero_hi = '0;

  // Operation decode; the default arm keeps the output defined for any code.
  always_comb begin
    result = '0;
    case (alu_op_e'(opcode))
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_MUL:  result = a_ext * b_ext;
      OP_AND:  result = {zero_hi, a & b};
      OP_OR:   result = {zero_hi, a | b};
      OP_NOT:  result = {zero_hi, ~a};
      OP_XOR:  result = {zero_hi, a ^ b};
      OP_XNOR: result = {zero_hi, ~(a ^ b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// ALU top: one register stage behind the combinational datapath.
// A valid input is captured on the edge it is presented; rslt holds its
// value when no valid input arrives. Reset is synchronous and wins over
// in_valid, discarding any operation presented in the same cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  input  logic               in_valid,
  output logic [2*WIDTH-1:0] rslt,
  output logic               out_valid
);

  logic [2*WIDTH-1:0] comb_result;
  logic [2*WIDTH-1:0] rslt_d;
  logic [2*WIDTH-1:0] rslt_q;
  logic               out_valid_d;
  logic               out_valid_q;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .result (comb_result)
  );

  // Next-state: load on valid, otherwise hold; out_valid follows in_valid.
  always_comb begin
    rslt_d      = rslt_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      rslt_d = comb_result;
    end
  end

  // Output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rslt_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rslt_q      <= rslt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rslt      = rslt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu top at WIDTH=4.
module tb_alu;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     opcode;
  logic           in_valid;
  logic [2*W-1:0] rslt;
  logic           out_valid;

  int errors = 0;
  int checks = 0;

  alu #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .in_valid  (in_valid),
    .rslt      (rslt),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one valid operation at the falling edge, let it be captured on
  // the next rising edge, sample 1 ns later, then drop in_valid.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        output logic [2*W-1:0] r, output logic v);
    @(negedge clk);
    opcode   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    r        = rslt;
    v        = out_valid;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rslt !== 8'h00) begin
      errors++;
      $display("FAIL reset_rslt got=%h want=00", rslt);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    logic [2:0]     ops [8];
    logic [W-1:0]   xs  [8];
    logic [W-1:0]   ys  [8];
    logic [2*W-1:0] exp [8];
    logic [2*W-1:0] r;
    logic           v;
    ops = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010};
    xs  = '{4'b0001, 4'b0110, 4'b1100, 4'b1101, 4'b0011, 4'b1100, 4'b1111, 4'b1111};
    ys  = '{4'b0010, 4'b0110, 4'b0011, 4'b1010, 4'b0101, 4'b0111, 4'b0011, 4'b1111};
    exp = '{8'b00000011, 8'b00001100, 8'b00001001, 8'b00000011,
            8'b11111110, 8'b01010100, 8'b00101101, 8'b11100001};
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], xs[i], ys[i], r, v);
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("FAIL arith%0d op=%b a=%b b=%b rslt got=%b want=%b",
                 i, ops[i], xs[i], ys[i], r, exp[i]);
      end
      checks++;
      if (v !== 1'b1) begin
        errors++;
        $display("FAIL arith%0d_valid got=%b want=1", i, v);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0]     ops [5];
    logic [W-1:0]   xs  [5];
    logic [W-1:0]   ys  [5];
    logic [2*W-1:0] exp [5];
    logic [2*W-1:0] r;
    logic           v;
    ops = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    xs  = '{4'b1101, 4'b1001, 4'b1001, 4'b0111, 4'b0011};
    ys  = '{4'b1011, 4'b1010, 4'b1111, 4'b1011, 4'b1110};
    exp = '{8'b00001001, 8'b00001011, 8'b00000110, 8'b00001100, 8'b00000010};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], xs[i], ys[i], r, v);
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("FAIL logic%0d op=%b a=%b b=%b rslt got=%b want=%b",
                 i, ops[i], xs[i], ys[i], r, exp[i]);
      end
      checks++;
      if (v !== 1'b1) begin
        errors++;
        $display("FAIL logic%0d_valid got=%b want=1", i, v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] r;
    logic           v;
    logic [2*W-1:0] exp [3];
    logic [2:0]     ops [3];
    logic [W-1:0]   xs  [3];
    logic [W-1:0]   ys  [3];
    ops = '{3'b000, 3'b010, 3'b110};
    xs  = '{4'b0101, 4'b0011, 4'b1010};
    ys  = '{4'b0100, 4'b0101, 4'b0110};
    exp = '{8'h09, 8'h0F, 8'h0C};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], xs[i], ys[i], r, v);
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("FAIL b2b%0d rslt got=%h want=%h", i, r, exp[i]);
      end
      checks++;
      if (v !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d_valid got=%b want=1", i, v);
      end
    end
    // Idle for two edges with different operands on the bus: result must hold.
    @(negedge clk);
    a      = 4'b1111;
    b      = 4'b1111;
    opcode = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got=%b want=0", out_valid);
    end
    checks++;
    if (rslt !== 8'h0C) begin
      errors++;
      $display("FAIL idle_hold rslt got=%h want=0c", rslt);
    end
  endtask

  task automatic test_reset_priority();
    logic [2*W-1:0] r;
    logic           v;
    run_op(3'b010, 4'b0111, 4'b0111, r, v);
    checks++;
    if (r !== 8'h31) begin
      errors++;
      $display("FAIL pre_reset rslt got=%h want=31", r);
    end
    // Raise reset and a valid ADD mid-cycle; nothing may change before the edge.
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    opcode   = 3'b000;
    a        = 4'b1111;
    b        = 4'b1111;
    #1;
    checks++;
    if (rslt !== 8'h31 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_async rslt got=%h valid got=%b want=31/1", rslt, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rslt !== 8'h00) begin
      errors++;
      $display("FAIL rst_prio rslt got=%h want=00", rslt);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio_valid got=%b want=0", out_valid);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    run_op(3'b000, 4'b1111, 4'b1111, r, v);
    checks++;
    if (r !== 8'h1E || v !== 1'b1) begin
      errors++;
      $display("FAIL post_rst rslt got=%h valid got=%b want=1e/1", r, v);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    opcode   = '0;
    test_reset();
    test_arith();
    test_logic();
    test_back_to_back();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
